// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller:
// FSM encoding, prescale constants and prescale decode.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    // Unsupported ratios fall back to x8.
    function automatic logic [5:0] presc_decode(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            PRESC_16: r = PRESC_16;
            PRESC_32: r = PRESC_32;
            default:  r = PRESC_8;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter with 3-tap capture around mid-bit
// and a 2-of-3 majority vote.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int EDGE_W = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start_i,
    input  logic       run_i,
    input  logic [5:0] presc_i,
    input  logic       rx_i,
    output logic       wrap_o,
    output logic       sample_done_o,
    output logic       vote_o
);

    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [EDGE_W-1:0] last, mid;
    logic [2:0]        tap_q, tap_d;

    assign last = EDGE_W'(presc_i - 6'd1);
    assign mid  = EDGE_W'(presc_i >> 1);

    assign wrap_o        = run_i && (edge_q == last);
    assign sample_done_o = run_i && (edge_q == mid + EDGE_W'(2));
    assign vote_o        = (tap_q[0] & tap_q[1]) |
                           (tap_q[0] & tap_q[2]) |
                           (tap_q[1] & tap_q[2]);

    // Edge 0 of the start bit is spent in IDLE, so a new frame loads 1.
    always_comb begin
        edge_d = '0;
        if (start_i) begin
            edge_d = EDGE_W'(1);
        end else if (run_i) begin
            edge_d = wrap_o ? '0 : edge_q + EDGE_W'(1);
        end
    end

    always_comb begin
        tap_d = tap_q;
        if (run_i) begin
            if (edge_q == mid - EDGE_W'(1)) tap_d[0] = rx_i;
            if (edge_q == mid)              tap_d[1] = rx_i;
            if (edge_q == mid + EDGE_W'(1)) tap_d[2] = rx_i;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_q <= '0;
            tap_q  <= '0;
        end else begin
            edge_q <= edge_d;
            tap_q  <= tap_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl_param.sv
// UART receive controller: frame FSM, deserialiser,
// parity/stop checking and registered result pulses.
module uart_rx_ctrl_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int EDGE_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [5:0]        PRESCALE,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    output logic [DATA_W-1:0] P_DATA,
    output logic              DATA_VALID,
    output logic              PAR_ERR,
    output logic              STP_ERR,
    output logic              BUSY
);

    state_e            state_q, state_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              serr_q, serr_d;
    logic [5:0]        presc_q, presc_d;
    logic              pen_q, pen_d;
    logic              ptyp_q, ptyp_d;
    logic              stop2_q, stop2_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              dv_q, dv_d;
    logic              pe_q, pe_d;
    logic              se_q, se_d;

    logic start, run, wrap, sdone, vote;

    assign start = (state_q == ST_IDLE) && !RX_IN;
    assign run   = (state_q == ST_START) || (state_q == ST_DATA) ||
                   (state_q == ST_PARITY) || (state_q == ST_STOP);

    uart_rx_sampler #(
        .EDGE_W(EDGE_W)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .start_i       (start),
        .run_i         (run),
        .presc_i       (presc_q),
        .rx_i          (RX_IN),
        .wrap_o        (wrap),
        .sample_done_o (sdone),
        .vote_o        (vote)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        presc_d = presc_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        stop2_d = stop2_q;
        pdata_d = pdata_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d = ST_START;
                    presc_d = presc_decode(PRESCALE);
                    pen_d   = PAR_EN;
                    ptyp_d  = PAR_TYP;
                    stop2_d = STOP2;
                    perr_d  = 1'b0;
                    serr_d  = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (sdone && vote) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (sdone) shift_d = {vote, shift_q[DATA_W-1:1]};
                if (wrap) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_W - 1)) begin
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end
                end
            end
            ST_PARITY: begin
                if (sdone && (vote != (^shift_q ^ ptyp_q))) perr_d = 1'b1;
                if (wrap) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (sdone && !vote) serr_d = 1'b1;
                if (wrap) begin
                    if (stop2_q && (bit_q == 4'd0)) bit_d = 4'd1;
                    else                            state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                pe_d    = perr_q;
                se_d    = serr_q;
                if (!perr_q && !serr_q) begin
                    dv_d    = 1'b1;
                    pdata_d = shift_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            presc_q <= PRESC_8;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            stop2_q <= 1'b0;
            pdata_q <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            presc_q <= presc_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            stop2_q <= stop2_d;
            pdata_q <= pdata_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// Bench for uart_rx_ctrl_param: directed frames into 8-bit and
// 7-bit instances, expected pulses checked from a scoreboard.
module tb_uart_rx_ctrl_param;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx7 = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;

    logic [7:0] pd8;
    logic [6:0] pd7;
    logic       dv8, pe8, se8, bz8;
    logic       dv7, pe7, se7, bz7;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [8:0] d;
        int         at;
    } exp_t;

    exp_t q8[$];
    exp_t q7[$];

    uart_rx_ctrl_param #(.DATA_W(8), .EDGE_W(5)) dut8 (
        .CLK(CLK), .RST(RST), .RX_IN(rx8), .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .P_DATA(pd8), .DATA_VALID(dv8), .PAR_ERR(pe8),
        .STP_ERR(se8), .BUSY(bz8)
    );

    uart_rx_ctrl_param #(.DATA_W(7), .EDGE_W(5)) dut7 (
        .CLK(CLK), .RST(RST), .RX_IN(rx7), .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .P_DATA(pd7), .DATA_VALID(dv7), .PAR_ERR(pe7),
        .STP_ERR(se7), .BUSY(bz7)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_pulse(input int id, input logic dv,
                             input logic pe, input logic se,
                             input logic [8:0] d);
        exp_t e;
        n_vec++;
        if ((id == 8 && q8.size() == 0) ||
            (id == 7 && q7.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_pulse dut%0d cyc %0d: dv=%b pe=%b se=%b d=%h, none expected",
                     id, cyc, dv, pe, se, d);
            return;
        end
        if (id == 8) e = q8.pop_front();
        else         e = q7.pop_front();
        if (dv !== e.dv || pe !== e.pe || se !== e.se ||
            d !== e.d || cyc != e.at) begin
            n_err++;
            $display("FAIL pulse dut%0d: got dv=%b pe=%b se=%b d=%h cyc=%0d expected dv=%b pe=%b se=%b d=%h cyc=%0d",
                     id, dv, pe, se, d, cyc, e.dv, e.pe, e.se, e.d, e.at);
        end
    endtask

    // Monitor: every result pulse is matched against the scoreboard.
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            if (dv8 || pe8 || se8) chk_pulse(8, dv8, pe8, se8, {1'b0, pd8});
            if (dv7 || pe7 || se7) chk_pulse(7, dv7, pe7, se7, {2'b0, pd7});
        end
    end

    task automatic push_exp(input int id, input logic dv, input logic pe,
                            input logic se, input logic [8:0] d,
                            input int nbits, input int p);
        exp_t e;
        e.dv = dv;
        e.pe = pe;
        e.se = se;
        e.d  = d;
        e.at = cyc + nbits * p + 1;
        if (id == 8) q8.push_back(e);
        else         q7.push_back(e);
    endtask

    task automatic drive(input int id, input logic v);
        if (id == 8) rx8 = v;
        else         rx7 = v;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int id, input int p, input logic [8:0] data,
                        input int dw, input logic pen, input logic pbit,
                        input logic s1, input logic s2, input logic two,
                        input int spk_bit, input int spk_edge,
                        input int abort_bit, input bit mess);
        logic       bits[$];
        logic [5:0] sv_p;
        logic       sv_pen, sv_s2, v;
        sv_p   = PRESCALE;
        sv_pen = PAR_EN;
        sv_s2  = STOP2;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(s1);
        if (two) bits.push_back(s2);
        for (int k = 0; k < bits.size(); k++) begin
            for (int e = 0; e < p; e++) begin
                if (k == abort_bit && e == p / 2) begin
                    RST = 1'b0;
                    #1;
                    chk("rst_busy", 32'(bz7), 32'd0);
                    chk("rst_pdata", 32'(pd7), 32'd0);
                    chk("rst_valid", 32'(dv7), 32'd0);
                    tick();
                    drive(id, 1'b1);
                    RST = 1'b1;
                    tick();
                    chk("post_rst_busy", 32'(bz7), 32'd0);
                    return;
                end
                v = bits[k] ^ (k == spk_bit && e == spk_edge);
                drive(id, v);
                if (mess && k == 2 && e == 0) begin
                    PRESCALE = 6'd32;
                    PAR_EN   = ~sv_pen;
                    STOP2    = ~sv_s2;
                end
                tick();
            end
        end
        drive(id, 1'b1);
        PRESCALE = sv_p;
        PAR_EN   = sv_pen;
        STOP2    = sv_s2;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_pdata", 32'(pd8), 32'd0);
        chk("reset_valid", 32'({dv8, pe8, se8}), 32'd0);
        chk("reset_busy", 32'(bz8), 32'd0);
        RST = 1'b1;
        repeat (2) tick();
        chk("idle_busy", 32'(bz8), 32'd0);

        // x8, 8N1, 0xA5: pulse in cycle 81
        PRESCALE = 6'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
        push_exp(8, 1, 0, 0, 9'h0A5, 10, 8);
        send(8, 8, 9'h0A5, 8, 0, 0, 1, 1, 0, -1, 0, -1, 0);

        // x16 even parity: good then bad parity
        PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        push_exp(8, 1, 0, 0, 9'h03C, 11, 16);
        send(8, 16, 9'h03C, 8, 1, 0, 1, 1, 0, -1, 0, -1, 0);
        push_exp(8, 0, 1, 0, 9'h03C, 11, 16);
        send(8, 16, 9'h03C, 8, 1, 1, 1, 1, 0, -1, 0, -1, 0);

        // start glitch of 3 cycles
        PAR_EN = 1'b0;
        rx8 = 1'b0;
        tick();
        chk("glitch_busy_hi", 32'(bz8), 32'd1);
        tick();
        tick();
        rx8 = 1'b1;
        repeat (9) tick();
        chk("glitch_busy_lo", 32'(bz8), 32'd0);

        // real frame, config disturbed mid-frame
        push_exp(8, 1, 0, 0, 9'h096, 10, 16);
        send(8, 16, 9'h096, 8, 0, 0, 1, 1, 0, -1, 0, -1, 1);

        // x32, two stop bits, second one low
        PRESCALE = 6'd32; STOP2 = 1'b1;
        push_exp(8, 0, 0, 1, 9'h096, 11, 32);
        send(8, 32, 9'h05A, 8, 0, 0, 1, 0, 1, -1, 0, -1, 0);

        // x16, spike on edge 8 of data bit 3
        PRESCALE = 6'd16; STOP2 = 1'b0;
        push_exp(8, 1, 0, 0, 9'h055, 10, 16);
        send(8, 16, 9'h055, 8, 0, 0, 1, 1, 0, 4, 8, -1, 0);

        // odd parity, two good stop bits, odd prescale -> x8
        PRESCALE = 6'd5; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1;
        push_exp(8, 1, 0, 0, 9'h001, 12, 8);
        send(8, 8, 9'h001, 8, 1, 0, 1, 1, 1, -1, 0, -1, 0);

        // parity and stop errors together
        PRESCALE = 6'd0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        push_exp(8, 0, 1, 1, 9'h001, 11, 8);
        send(8, 8, 9'h081, 8, 1, 1, 0, 1, 0, -1, 0, -1, 0);

        // 7-bit instance: good frame, aborted frame, back-to-back pair
        PRESCALE = 6'd8; PAR_EN = 1'b0;
        repeat (4) tick();
        push_exp(7, 1, 0, 0, 9'h015, 9, 8);
        send(7, 8, 9'h015, 7, 0, 0, 1, 1, 0, -1, 0, -1, 0);
        repeat (4) tick();
        send(7, 8, 9'h02A, 7, 0, 0, 1, 1, 0, -1, 0, 5, 0);
        push_exp(7, 1, 0, 0, 9'h000, 9, 8);
        send(7, 8, 9'h000, 7, 0, 0, 1, 1, 0, -1, 0, -1, 0);
        push_exp(7, 1, 0, 0, 9'h07F, 9, 8);
        send(7, 8, 9'h07F, 7, 0, 0, 1, 1, 0, -1, 0, -1, 0);

        repeat (30) tick();
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q7_drained", 32'(q7.size()), 32'd0);
        chk("end_busy", 32'({bz8, bz7}), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
